// File: rtl/rf_port_sched_pkg.sv
// rtl/rf_port_sched_pkg.sv - shared types for the register-file port scheduler
package rf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWP_RD = 2'd1,
        SWP_WA = 2'd2,
        SWP_WB = 2'd3
    } state_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_t;

    localparam int SWAP_CYCLES = 3;

endpackage

// File: rtl/rf_port_sched_if.sv
// rtl/rf_port_sched_if.sv - requester, swap, datapath and register-file port bundle
interface rf_port_sched_if #(
    parameter int PW = 4,
    parameter int DW = 8
);
    logic          alu_req;
    logic [PW:0]   alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_gnt;
    logic          ld_req;
    logic [PW:0]   ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_gnt;
    logic          swp_req;
    logic [PW:0]   swp_addrA;
    logic [PW:0]   swp_addrB;
    logic          swp_busy;
    logic          swp_done;
    logic [PW:0]   dp_rd_addrA;
    logic [PW:0]   dp_rd_addrB;
    logic          dp_rd_stall;
    logic [PW:0]   rf_rd_addrA;
    logic [PW:0]   rf_rd_addrB;
    logic [DW-1:0] rf_datA;
    logic [DW-1:0] rf_datB;
    logic          rf_wr_en;
    logic [PW:0]   rf_wr_addr;
    logic [DW-1:0] rf_dat_in;

    // Scheduler side.
    modport slave (
        input  alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
        input  swp_req, swp_addrA, swp_addrB, dp_rd_addrA, dp_rd_addrB,
        input  rf_datA, rf_datB,
        output alu_gnt, ld_gnt, swp_busy, swp_done, dp_rd_stall,
        output rf_rd_addrA, rf_rd_addrB, rf_wr_en, rf_wr_addr, rf_dat_in
    );

    // Requesters, datapath and register file side.
    modport master (
        output alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
        output swp_req, swp_addrA, swp_addrB, dp_rd_addrA, dp_rd_addrB,
        output rf_datA, rf_datB,
        input  alu_gnt, ld_gnt, swp_busy, swp_done, dp_rd_stall,
        input  rf_rd_addrA, rf_rd_addrB, rf_wr_en, rf_wr_addr, rf_dat_in
    );
endinterface

// File: rtl/rf_port_sched_arb.sv
// rtl/rf_port_sched_arb.sv - 2-way round-robin arbiter (bit 0 = ALU, bit 1 = load)
module rr_arb2
    import rf_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_t rr_last_q;
    req_t rr_last_d;

    // History only moves on a contested grant, so a lone requester never steals priority.
    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        if (enable) begin
            if (req == 2'b11) begin
                if (rr_last_q == REQ_LD) begin
                    gnt       = 2'b01;
                    rr_last_d = REQ_ALU;
                end else begin
                    gnt       = 2'b10;
                    rr_last_d = REQ_LD;
                end
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= REQ_LD;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/rf_port_sched.sv
// rtl/rf_port_sched.sv - owns the register file write port and read-address ports
module rf_port_sched
    import rf_sched_pkg::*;
#(
    parameter int PW = 4,
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_port_sched_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SWP_RD = SWP_RD;
    localparam logic [1:0] ST_SWP_WA = SWP_WA;
    localparam logic [1:0] ST_SWP_WB = SWP_WB;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] cap_a_q, cap_a_d;
    logic [DW-1:0] cap_b_q, cap_b_d;
    logic [PW:0]   lat_a_q, lat_a_d;
    logic [PW:0]   lat_b_q, lat_b_d;
    logic [1:0]    gnt;
    logic          arb_en;

    // A pending swap blocks arbitration so the history is not advanced by a grant that never happens.
    assign arb_en = rst_n && (state_q == ST_IDLE) && !bus.swp_req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (arb_en),
        .req    ({bus.ld_req, bus.alu_req}),
        .gnt    (gnt)
    );

    always_comb begin
        state_d         = state_q;
        cap_a_d         = cap_a_q;
        cap_b_d         = cap_b_q;
        lat_a_d         = lat_a_q;
        lat_b_d         = lat_b_q;
        bus.alu_gnt     = gnt[0];
        bus.ld_gnt      = gnt[1];
        bus.rf_rd_addrA = bus.dp_rd_addrA;
        bus.rf_rd_addrB = bus.dp_rd_addrB;
        bus.dp_rd_stall = 1'b0;
        bus.rf_wr_en    = |gnt;
        bus.rf_wr_addr  = gnt[1] ? bus.ld_addr : bus.alu_addr;
        bus.rf_dat_in   = gnt[1] ? bus.ld_data : bus.alu_data;
        bus.swp_busy    = 1'b0;
        bus.swp_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.swp_req) begin
                    state_d = ST_SWP_RD;
                end
            end
            ST_SWP_RD: begin
                bus.rf_rd_addrA = bus.swp_addrA;
                bus.rf_rd_addrB = bus.swp_addrB;
                bus.dp_rd_stall = 1'b1;
                bus.swp_busy    = 1'b1;
                cap_a_d         = bus.rf_datA;
                cap_b_d         = bus.rf_datB;
                lat_a_d         = bus.swp_addrA;
                lat_b_d         = bus.swp_addrB;
                state_d         = ST_SWP_WA;
            end
            ST_SWP_WA: begin
                bus.dp_rd_stall = 1'b1;
                bus.swp_busy    = 1'b1;
                bus.rf_wr_en    = 1'b1;
                bus.rf_wr_addr  = lat_a_q;
                bus.rf_dat_in   = cap_b_q;
                state_d         = ST_SWP_WB;
            end
            ST_SWP_WB: begin
                bus.dp_rd_stall = 1'b1;
                bus.swp_busy    = 1'b1;
                bus.swp_done    = 1'b1;
                bus.rf_wr_en    = 1'b1;
                bus.rf_wr_addr  = lat_b_q;
                bus.rf_dat_in   = cap_a_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cap_a_q <= '0;
            cap_b_q <= '0;
            lat_a_q <= '0;
            lat_b_q <= '0;
        end else begin
            state_q <= state_d;
            cap_a_q <= cap_a_d;
            cap_b_q <= cap_b_d;
            lat_a_q <= lat_a_d;
            lat_b_q <= lat_b_d;
        end
    end

endmodule

// File: tb/tb_rf_port_sched.sv
// tb/tb_rf_port_sched.sv - directed bench with a register-file model and per-cycle output checks
module tb_rf_port_sched;
    import rf_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_port_sched_if #(.PW(4), .DW(8)) bus ();

    rf_port_sched #(.PW(4), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] rf     [32];
    logic [7:0] exp_rf [32];

    assign bus.rf_datA = rf[bus.rf_rd_addrA];
    assign bus.rf_datB = rf[bus.rf_rd_addrB];

    always @(posedge clk) begin
        if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_dat_in;
    end

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: phase 0 = idle, 1..3 = the three swap cycles.
    int         m_phase;
    logic       m_last_ld;
    logic [4:0] m_a, m_b;
    logic [7:0] m_ca, m_cb;
    logic       e_alu, e_ld, e_wr, e_stall, e_busy, e_done;
    logic [4:0] e_ra, e_rb, e_wa;
    logic [7:0] e_wd;

    always @(negedge clk) begin
        if (bus.swp_done) done_cnt++;
        if (!rst_n) begin
            m_phase   = 0;
            m_last_ld = 1'b1;
            chk("rst_alu_gnt", 32'(bus.alu_gnt), 0);
            chk("rst_ld_gnt", 32'(bus.ld_gnt), 0);
            chk("rst_wr_en", 32'(bus.rf_wr_en), 0);
            chk("rst_stall", 32'(bus.dp_rd_stall), 0);
            chk("rst_busy", 32'(bus.swp_busy), 0);
            chk("rst_done", 32'(bus.swp_done), 0);
        end else begin
            e_alu = 0; e_ld = 0; e_wr = 0; e_stall = 0; e_busy = 0; e_done = 0;
            e_ra = bus.dp_rd_addrA; e_rb = bus.dp_rd_addrB; e_wa = 0; e_wd = 0;
            if (m_phase == 0) begin
                if (bus.swp_req) begin
                    m_phase = 1;
                end else begin
                    if (bus.alu_req && bus.ld_req) begin
                        e_alu = m_last_ld;
                        e_ld  = !m_last_ld;
                        m_last_ld = e_ld;
                    end else begin
                        e_alu = bus.alu_req;
                        e_ld  = bus.ld_req;
                    end
                    e_wr = e_alu | e_ld;
                    e_wa = e_ld ? bus.ld_addr : bus.alu_addr;
                    e_wd = e_ld ? bus.ld_data : bus.alu_data;
                end
            end else begin
                e_stall = 1; e_busy = 1;
                if (m_phase == 1) begin
                    e_ra = bus.swp_addrA; e_rb = bus.swp_addrB;
                    m_a = bus.swp_addrA; m_b = bus.swp_addrB;
                    m_ca = exp_rf[m_a]; m_cb = exp_rf[m_b];
                end else if (m_phase == 2) begin
                    e_wr = 1; e_wa = m_a; e_wd = m_cb;
                end else begin
                    e_wr = 1; e_wa = m_b; e_wd = m_ca; e_done = 1;
                end
                m_phase = (m_phase == SWAP_CYCLES) ? 0 : m_phase + 1;
            end
            chk("alu_gnt", 32'(bus.alu_gnt), 32'(e_alu));
            chk("ld_gnt", 32'(bus.ld_gnt), 32'(e_ld));
            chk("rf_wr_en", 32'(bus.rf_wr_en), 32'(e_wr));
            chk("dp_rd_stall", 32'(bus.dp_rd_stall), 32'(e_stall));
            chk("swp_busy", 32'(bus.swp_busy), 32'(e_busy));
            chk("swp_done", 32'(bus.swp_done), 32'(e_done));
            chk("rf_rd_addrA", 32'(bus.rf_rd_addrA), 32'(e_ra));
            chk("rf_rd_addrB", 32'(bus.rf_rd_addrB), 32'(e_rb));
            if (e_wr) begin
                chk("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(e_wa));
                chk("rf_dat_in", 32'(bus.rf_dat_in), 32'(e_wd));
                exp_rf[e_wa] = e_wd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        rf[a]     = d;
        exp_rf[a] = d;
    endtask

    logic [1:0] g [4];
    int         busy_n, gnt_n, wr_n;

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]     = 8'h00;
            exp_rf[i] = 8'h00;
        end
        rst_n = 1'b0;
        bus.alu_req = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.ld_req = 0; bus.ld_addr = 0; bus.ld_data = 0;
        bus.swp_req = 0; bus.swp_addrA = 0; bus.swp_addrB = 0;
        bus.dp_rd_addrA = 5'd1; bus.dp_rd_addrB = 5'h1F;
        bus.alu_req = 1;
        tick(); tick();
        rst_n = 1'b1;

        // Single ALU write, granted in the same cycle.
        bus.alu_req = 1; bus.alu_addr = 5'd3; bus.alu_data = 8'h5A;
        @(negedge clk);
        chk("t1_alu_gnt", 32'(bus.alu_gnt), 1);
        chk("t1_wr_en", 32'(bus.rf_wr_en), 1);
        chk("t1_wr_addr", 32'(bus.rf_wr_addr), 3);
        chk("t1_dat_in", 32'(bus.rf_dat_in), 32'h5A);
        tick();
        bus.alu_req = 0;
        chk("t1_rf3", 32'(rf[3]), 32'h5A);

        // Contested requests alternate, starting with ALU after reset; upper address bit passes through.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.alu_req = 1; bus.alu_addr = 5'h13; bus.alu_data = 8'h31;
        bus.ld_req = 1; bus.ld_addr = 5'h11; bus.ld_data = 8'hC4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g[i] = {bus.ld_gnt, bus.alu_gnt};
            tick();
        end
        bus.alu_req = 0; bus.ld_req = 0;
        chk("t2_g0", 32'(g[0]), 32'b01);
        chk("t2_g1", 32'(g[1]), 32'b10);
        chk("t2_g2", 32'(g[2]), 32'b01);
        chk("t2_g3", 32'(g[3]), 32'b10);
        chk("t2_rf19", 32'(rf[19]), 32'h31);
        chk("t2_rf17", 32'(rf[17]), 32'hC4);

        // Swap R2/R7.
        preload(5'd2, 8'h11);
        preload(5'd7, 8'hEE);
        bus.swp_req = 1; bus.swp_addrA = 5'd2; bus.swp_addrB = 5'd7;
        busy_n = 0;
        @(negedge clk);
        busy_n += 32'(bus.swp_busy);
        tick();
        bus.swp_req = 0;
        @(negedge clk);
        busy_n += 32'(bus.swp_busy);
        chk("t3_rdA", 32'(bus.rf_rd_addrA), 2);
        chk("t3_rdB", 32'(bus.rf_rd_addrB), 7);
        chk("t3_stall", 32'(bus.dp_rd_stall), 1);
        tick();
        bus.swp_addrA = 5'd0; bus.swp_addrB = 5'd0;
        @(negedge clk);
        busy_n += 32'(bus.swp_busy);
        chk("t3_wa_addr", 32'(bus.rf_wr_addr), 2);
        chk("t3_wa_dat", 32'(bus.rf_dat_in), 32'hEE);
        chk("t3_wa_done", 32'(bus.swp_done), 0);
        tick();
        @(negedge clk);
        busy_n += 32'(bus.swp_busy);
        chk("t3_wb_addr", 32'(bus.rf_wr_addr), 7);
        chk("t3_wb_dat", 32'(bus.rf_dat_in), 32'h11);
        chk("t3_wb_done", 32'(bus.swp_done), 1);
        tick();
        @(negedge clk);
        busy_n += 32'(bus.swp_busy);
        chk("t3_busy_cycles", 32'(busy_n), 32'(SWAP_CYCLES));
        chk("t3_rf2", 32'(rf[2]), 32'hEE);
        chk("t3_rf7", 32'(rf[7]), 32'h11);
        tick();

        // Swap outranks a simultaneous ALU request; ALU served once idle again.
        bus.alu_req = 1; bus.alu_addr = 5'd9; bus.alu_data = 8'h77;
        bus.swp_req = 1; bus.swp_addrA = 5'd2; bus.swp_addrB = 5'd7;
        gnt_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gnt_n += 32'(bus.alu_gnt);
            tick();
            bus.swp_req = 0;
        end
        @(negedge clk);
        chk("t4_held_gnts", 32'(gnt_n), 0);
        chk("t4_alu_gnt", 32'(bus.alu_gnt), 1);
        chk("t4_wr_addr", 32'(bus.rf_wr_addr), 9);
        chk("t4_dat_in", 32'(bus.rf_dat_in), 32'h77);
        tick();
        bus.alu_req = 0;
        chk("t4_rf2", 32'(rf[2]), 32'h11);
        chk("t4_rf7", 32'(rf[7]), 32'hEE);
        chk("t4_rf9", 32'(rf[9]), 32'h77);

        // Reset asserted during the first swap write.
        preload(5'd4, 8'hAA);
        preload(5'd6, 8'hBB);
        done_cnt = 0;
        bus.swp_req = 1; bus.swp_addrA = 5'd4; bus.swp_addrB = 5'd6;
        tick();
        bus.swp_req = 0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(bus.swp_busy), 0);
        chk("t5_wr_en", 32'(bus.rf_wr_en), 0);
        tick();
        chk("t5_rf4", 32'(rf[4]), 32'hAA);
        chk("t5_rf6", 32'(rf[6]), 32'hBB);
        chk("t5_no_done", 32'(done_cnt), 0);

        // Self-swap rewrites the same value twice.
        preload(5'd5, 8'h42);
        bus.swp_req = 1; bus.swp_addrA = 5'd5; bus.swp_addrB = 5'd5;
        wr_n = 0;
        tick();
        bus.swp_req = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (bus.rf_wr_en && bus.rf_wr_addr == 5'd5 && bus.rf_dat_in == 8'h42) wr_n++;
            if (i == 3) chk("t6_done", 32'(bus.swp_done), 1);
            tick();
        end
        chk("t6_writes", 32'(wr_n), 2);
        chk("t6_rf5", 32'(rf[5]), 32'h42);

        for (int i = 0; i < 32; i++) begin
            chk("final_rf", {24'd0, rf[i]}, {24'd0, exp_rf[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
